// File: rtl/rv32i_types.sv
// Shared RV32I types: opcode enumeration, decoded fetch record and immediate helpers.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
  } pci_t;

  function automatic pci_t make_pci_default();
    pci_t p;
    p = '0;
    p.opcode = op_imm;
    return p;
  endfunction

  // Bubble record: an op_imm with every other field zero (a nop-like slot).
  localparam pci_t pci_default = make_pci_default();

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/pc_info_decode.sv
// Combinational decode of a fetched word and its address into a pci_t record.
module pc_info_decode
  import rv32i_types::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output pci_t        pci
);

  // Split the instruction into its fields and sign-extended immediates.
  always_comb begin
    pci         = pci_default;
    pci.pc      = pc;
    pci.next_pc = pc + 32'd4;
    pci.instr   = instr;
    pci.opcode  = rv32i_opcode'(instr[6:0]);
    pci.funct3  = instr[14:12];
    pci.funct7  = instr[31:25];
    pci.rs1     = instr[19:15];
    pci.rs2     = instr[24:20];
    pci.rd      = instr[11:7];
    pci.i_imm   = imm_i(instr);
    pci.s_imm   = imm_s(instr);
    pci.b_imm   = imm_b(instr);
    pci.u_imm   = imm_u(instr);
    pci.j_imm   = imm_j(instr);
  end

endmodule

// File: rtl/instruction_queue.sv
// Fetch unit plus circular instruction queue between instruction memory and the ROB.
// One request is outstanding at a time; a flush with a request in flight drops its response.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int               width    = 32,
  parameter int               size     = 8,
  parameter logic [width-1:0] reset_pc = 32'h00000060
) (
  input  logic             clk,
  input  logic             rst,
  output logic             instr_mem_read,
  output logic [width-1:0] instr_mem_address,
  input  logic             instr_mem_resp,
  input  logic [width-1:0] instr_mem_rdata,
  input  logic             instr_q_dequeue,
  output pci_t             pci,
  output logic             instr_q_empty,
  input  logic             br_flush,
  input  logic [width-1:0] br_target
);

  localparam int ptr_w = $clog2(size);
  localparam logic [ptr_w:0] size_cnt = (ptr_w + 1)'(size);

  typedef enum logic [1:0] {
    st_fetch = 2'd0,
    st_stall = 2'd1,
    st_drop  = 2'd2
  } fetch_state_t;

  fetch_state_t     state;
  logic [width-1:0] pc;
  pci_t             entries [size];
  logic [ptr_w-1:0] front;
  logic [ptr_w-1:0] rear;
  logic [ptr_w:0]   count;
  logic [ptr_w:0]   count_next;
  pci_t             resp_pci;
  logic             empty;
  logic             full;
  logic             resp_take;
  logic             bypass;
  logic             enq;
  logic             deq;
  logic             outstanding;

  pc_info_decode u_decode (
    .pc    (pc),
    .instr (instr_mem_rdata),
    .pci   (resp_pci)
  );

  assign empty             = (count == '0);
  assign full              = (count == size_cnt);
  assign instr_q_empty     = empty;
  assign instr_mem_address = pc;

  // A response belongs to us only when it answers a request issued in FETCH.
  assign resp_take   = instr_mem_resp && (state == st_fetch) && instr_mem_read;
  assign bypass      = empty && resp_take && instr_q_dequeue;
  assign enq         = resp_take && !bypass && !br_flush && (!full || instr_q_dequeue);
  assign deq         = instr_q_dequeue && !empty && !br_flush;
  assign outstanding = ((state == st_fetch) && instr_mem_read && !instr_mem_resp) ||
                       ((state == st_drop) && !instr_mem_resp);

  // Occupancy after this cycle's enqueue/dequeue, ignoring flush.
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + (ptr_w + 1)'(1);
      2'b01:   count_next = count - (ptr_w + 1)'(1);
      default: count_next = count;
    endcase
  end

  // Front entry when stored, otherwise the live response, otherwise a bubble.
  always_comb begin
    pci = pci_default;
    if (!empty) begin
      pci = entries[front];
    end else if (resp_take) begin
      pci = resp_pci;
    end
  end

  // Fetch FSM: owns pc, state and the registered read strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= st_fetch;
      instr_mem_read <= 1'b0;
      pc             <= {reset_pc[width-1:2], 2'b00};
    end else if (br_flush) begin
      pc <= {br_target[width-1:2], 2'b00};
      if (outstanding) begin
        state          <= st_drop;
        instr_mem_read <= 1'b0;
      end else begin
        state          <= st_fetch;
        instr_mem_read <= 1'b1;
      end
    end else begin
      if (resp_take) begin
        pc <= pc + width'(4);
      end
      case (state)
        st_fetch: begin
          if (enq && (count_next == size_cnt)) begin
            state          <= st_stall;
            instr_mem_read <= 1'b0;
          end else begin
            instr_mem_read <= 1'b1;
          end
        end
        st_stall: begin
          if (count_next < size_cnt) begin
            state          <= st_fetch;
            instr_mem_read <= 1'b1;
          end
        end
        st_drop: begin
          if (instr_mem_resp) begin
            state          <= st_fetch;
            instr_mem_read <= 1'b1;
          end
        end
        default: begin
          state          <= st_fetch;
          instr_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Circular buffer: write at rear, read at front, pointers wrap at size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      front <= '0;
      rear  <= '0;
      for (int i = 0; i < size; i++) begin
        entries[i] <= pci_default;
      end
    end else if (br_flush) begin
      count <= '0;
      front <= '0;
      rear  <= '0;
    end else begin
      if (enq) begin
        entries[rear] <= resp_pci;
        rear          <= rear + ptr_w'(1);
      end
      if (deq) begin
        front <= front + ptr_w'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: table vectors, directed corner sequences, then random traffic
// against a queue-based reference model with a one-outstanding-request memory.
module tb_instruction_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_mem_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        instr_q_dequeue;
  pci_t        pci;
  logic        instr_q_empty;
  logic        br_flush;
  logic [31:0] br_target;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ADD  = 32'h002081b3;
  localparam logic [31:0] LW   = 32'h0000a203;
  localparam logic [31:0] NOP  = 32'h00000013;

  always #5 clk = ~clk;

  instruction_queue #(.width(32), .size(8), .reset_pc(32'h00000060)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_mem_read    (instr_mem_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .instr_q_dequeue   (instr_q_dequeue),
    .pci               (pci),
    .instr_q_empty     (instr_q_empty),
    .br_flush          (br_flush),
    .br_target         (br_target)
  );

  typedef struct {
    logic        r;
    logic        resp;
    logic [31:0] rdata;
    logic        deq;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_empty;
    logic [31:0] e_pc;
    logic [6:0]  e_op;
  } vec_t;

  function automatic vec_t mk(logic r, logic resp, logic [31:0] rdata, logic deq,
                              logic e_read, logic [31:0] e_addr, logic e_empty,
                              logic [31:0] e_pc, logic [6:0] e_op);
    vec_t v;
    v.r = r; v.resp = resp; v.rdata = rdata; v.deq = deq;
    v.e_read = e_read; v.e_addr = e_addr; v.e_empty = e_empty; v.e_pc = e_pc; v.e_op = e_op;
    return v;
  endfunction

  function automatic pci_t ref_default();
    pci_t p;
    p = '0;
    p.opcode = op_imm;
    return p;
  endfunction

  // Reference decode built from arithmetic shifts rather than bit replication.
  function automatic pci_t ref_decode(logic [31:0] pc, logic [31:0] ins);
    pci_t               p;
    logic signed [31:0] sx;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] ext;
    p = '0;
    p.pc      = pc;
    p.next_pc = pc + 32'd4;
    p.instr   = ins;
    p.opcode  = rv32i_opcode'(ins[6:0]);
    p.funct3  = ins[14:12];
    p.funct7  = ins[31:25];
    p.rs1     = ins[19:15];
    p.rs2     = ins[24:20];
    p.rd      = ins[11:7];
    sx        = $signed(ins) >>> 20;
    p.i_imm   = sx;
    p.s_imm   = {sx[31:5], ins[11:7]};
    b13       = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ext       = b13;
    p.b_imm   = ext;
    p.u_imm   = ins & 32'hfffff000;
    j21       = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    ext       = j21;
    p.j_imm   = ext;
    return p;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0013;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pci(string name, pci_t exp);
    checks++;
    if (pci !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h instr=%h op=%h imm_i=%h expected pc=%h instr=%h op=%h imm_i=%h",
               name, pci.pc, pci.instr, pci.opcode, pci.i_imm,
               exp.pc, exp.instr, exp.opcode, exp.i_imm);
    end
  endtask

  task automatic drive(logic r, logic resp, logic [31:0] rdata, logic deq,
                       logic fl, logic [31:0] tgt);
    rst = r; instr_mem_resp = resp; instr_mem_rdata = rdata;
    instr_q_dequeue = deq; br_flush = fl; br_target = tgt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic reset_hold(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
  endtask

  // Reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_pc;
  bit          m_read;
  bit          m_drop;

  vec_t vecs[$];

  initial begin
    logic        r, resp, deq, fl, acc, was_empty, outst, busy;
    logic [31:0] rdata, tgt, lat_addr;
    int          dly;
    pci_t        exp_p;

    rst = 1'b0; instr_mem_resp = 1'b0; instr_mem_rdata = '0;
    instr_q_dequeue = 1'b0; br_flush = 1'b0; br_target = '0;
    tick();
    reset_hold(2);

    // ---- table vectors: three fetches, drain, empty-dequeue, reset with stray responses, bypass
    vecs.push_back(mk(0, 0, 0,    0, 0, 32'h60, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 0, 0,    0, 0, 32'h60, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 1, ADDI, 0, 1, 32'h60, 1, 32'h60, 7'h13));
    vecs.push_back(mk(1, 1, ADD,  0, 1, 32'h64, 0, 32'h60, 7'h13));
    vecs.push_back(mk(1, 1, LW,   0, 1, 32'h68, 0, 32'h60, 7'h13));
    vecs.push_back(mk(1, 0, 0,    0, 1, 32'h6c, 0, 32'h60, 7'h13));
    vecs.push_back(mk(1, 0, 0,    1, 1, 32'h6c, 0, 32'h60, 7'h13));
    vecs.push_back(mk(1, 0, 0,    1, 1, 32'h6c, 0, 32'h64, 7'h33));
    vecs.push_back(mk(1, 0, 0,    1, 1, 32'h6c, 0, 32'h68, 7'h03));
    vecs.push_back(mk(1, 0, 0,    0, 1, 32'h6c, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 0, 0,    1, 1, 32'h6c, 1, 32'h0,  7'h13));
    vecs.push_back(mk(0, 0, 0,    0, 1, 32'h6c, 1, 32'h0,  7'h13));
    vecs.push_back(mk(0, 1, NOP,  0, 0, 32'h60, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 1, NOP,  0, 0, 32'h60, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 0, 0,    0, 1, 32'h60, 1, 32'h0,  7'h13));
    vecs.push_back(mk(1, 1, NOP,  1, 1, 32'h60, 1, 32'h60, 7'h13));
    vecs.push_back(mk(1, 0, 0,    0, 1, 32'h64, 1, 32'h0,  7'h13));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].resp, vecs[i].rdata, vecs[i].deq, 1'b0, 32'h0);
      check32($sformatf("tbl%0d_read", i),  {31'b0, instr_mem_read}, {31'b0, vecs[i].e_read});
      check32($sformatf("tbl%0d_addr", i),  instr_mem_address, vecs[i].e_addr);
      check32($sformatf("tbl%0d_empty", i), {31'b0, instr_q_empty}, {31'b0, vecs[i].e_empty});
      check32($sformatf("tbl%0d_pc", i),    pci.pc, vecs[i].e_pc);
      check32($sformatf("tbl%0d_op", i),    {25'b0, pci.opcode}, {25'b0, vecs[i].e_op});
      tick();
    end

    // ---- fill to eight, stall, one dequeue restarts fetch at 0x80
    reset_hold(2);
    idle();
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, NOP | (i << 7), 1'b0, 1'b0, 32'h0);
      check32($sformatf("fill%0d_read", i), {31'b0, instr_mem_read}, 32'd1);
      check32($sformatf("fill%0d_addr", i), instr_mem_address, 32'h60 + 32'(4 * i));
      tick();
    end
    idle();
    check32("full_read_low", {31'b0, instr_mem_read}, 32'd0);
    check32("full_not_empty", {31'b0, instr_q_empty}, 32'd0);
    tick();
    idle();
    check32("stall_hold", {31'b0, instr_mem_read}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check32("full_front_pc", pci.pc, 32'h60);
    tick();

    // ---- enqueue+dequeue together, refill across the wrap, drain in order
    drive(1'b1, 1'b1, mem_word(32'h80), 1'b1, 1'b0, 32'h0);
    check32("restart_read", {31'b0, instr_mem_read}, 32'd1);
    check32("restart_addr", instr_mem_address, 32'h80);
    check32("both_front", pci.pc, 32'h64);
    tick();
    drive(1'b1, 1'b1, mem_word(32'h84), 1'b0, 1'b0, 32'h0);
    check32("both_read_kept", {31'b0, instr_mem_read}, 32'd1);
    check32("both_addr", instr_mem_address, 32'h84);
    tick();
    idle();
    check32("refull_read_low", {31'b0, instr_mem_read}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check32($sformatf("drain%0d_pc", k), pci.pc, 32'h68 + 32'(4 * k));
      check32($sformatf("drain%0d_empty", k), {31'b0, instr_q_empty}, 32'd0);
      tick();
    end
    idle();
    check32("drained_empty", {31'b0, instr_q_empty}, 32'd1);
    check_pci("drained_default", ref_default());
    check32("drained_addr", instr_mem_address, 32'h88);

    // ---- flush with a request in flight: response dropped, fetch resumes at 0x200
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    check32("flush_outstanding", {31'b0, instr_mem_read}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, 32'h0);
    check32("drop_read_low", {31'b0, instr_mem_read}, 32'd0);
    check32("drop_empty", {31'b0, instr_q_empty}, 32'd1);
    check_pci("drop_no_bypass", ref_default());
    tick();
    idle();
    check32("resume_read", {31'b0, instr_mem_read}, 32'd1);
    check32("resume_addr", instr_mem_address, 32'h200);
    check32("resume_empty", {31'b0, instr_q_empty}, 32'd1);
    tick();
    drive(1'b1, 1'b1, ADDI, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_pci("target_entry", ref_decode(32'h200, ADDI));
    tick();
    idle();
    check32("target_drained", {31'b0, instr_q_empty}, 32'd1);
    check32("target_next", instr_mem_address, 32'h204);
    tick();

    // ---- flush coincident with a response: response discarded, no drop state
    drive(1'b1, 1'b1, NOP, 1'b0, 1'b1, 32'h300);
    tick();
    idle();
    check32("coinc_read", {31'b0, instr_mem_read}, 32'd1);
    check32("coinc_addr", instr_mem_address, 32'h300);
    check32("coinc_empty", {31'b0, instr_q_empty}, 32'd1);
    tick();

    // ---- reset in the middle of a fill
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, NOP, 1'b0, 1'b0, 32'h0);
      tick();
    end
    idle();
    check32("midfill_nonempty", {31'b0, instr_q_empty}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    check32("midrst_read", {31'b0, instr_mem_read}, 32'd0);
    check32("midrst_addr", instr_mem_address, 32'h60);
    check32("midrst_empty", {31'b0, instr_q_empty}, 32'd1);
    tick();

    // ---- random traffic against the reference model
    reset_hold(2);
    mq_pc.delete(); mq_in.delete();
    m_pc = 32'h60; m_read = 0; m_drop = 0;
    busy = 0; dly = 0; lat_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom_range(0, 499) != 0);
      resp = 1'b0;
      rdata = $urandom;
      if (!busy && instr_mem_read) begin
        busy = 1'b1; lat_addr = instr_mem_address; dly = $urandom_range(0, 2);
      end
      if (busy && dly == 0) begin
        resp = 1'b1; rdata = mem_word(lat_addr);
      end
      deq = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      tgt = $urandom & 32'h0000fffc;
      drive(r, resp, rdata, deq, fl, tgt);

      if (mq_pc.size() != 0) exp_p = ref_decode(mq_pc[0], mq_in[0]);
      else if (resp && m_read) exp_p = ref_decode(m_pc, rdata);
      else exp_p = ref_default();
      check32($sformatf("rnd%0d_read", c), {31'b0, instr_mem_read}, {31'b0, m_read});
      check32($sformatf("rnd%0d_addr", c), instr_mem_address, m_pc);
      check32($sformatf("rnd%0d_empty", c), {31'b0, instr_q_empty}, {31'b0, mq_pc.size() == 0});
      check_pci($sformatf("rnd%0d_pci", c), exp_p);

      if (!r) begin
        mq_pc.delete(); mq_in.delete();
        m_pc = 32'h60; m_read = 0; m_drop = 0;
      end else if (fl) begin
        outst = (m_read || m_drop) && !resp;
        mq_pc.delete(); mq_in.delete();
        m_pc = tgt; m_drop = outst; m_read = !outst;
      end else if (m_drop) begin
        if (resp) begin m_drop = 0; m_read = 1; end
      end else begin
        acc = resp && m_read;
        was_empty = (mq_pc.size() == 0);
        if (deq && !was_empty) begin
          void'(mq_pc.pop_front()); void'(mq_in.pop_front());
        end
        if (acc) begin
          if (!(was_empty && deq)) begin
            mq_pc.push_back(m_pc); mq_in.push_back(rdata);
          end
          m_pc = m_pc + 32'd4;
        end
        if (m_read) m_read = !(acc && !(was_empty && deq) && mq_pc.size() == 8);
        else m_read = (mq_pc.size() < 8);
      end

      tick();
      if (resp) busy = 1'b0;
      else if (busy) dly--;
      if (!r) busy = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
